// File: rtl/pixel_stream_feeder.sv
// Raster-order pixel feeder: reads a frame from 1-cycle-latency memory and hands
// pixels to the detector one per ready episode. Optional PIXEL_FEEDER_CHECKSUM_EN adds o_checksum.
module pixel_stream_feeder #(
    parameter int DATA_WIDTH   = 12,
    parameter int FRAME_WIDTH  = 320,
    parameter int FRAME_HEIGHT = 240,
    parameter int ADDR_WIDTH   = 17,
    parameter int CONTINUOUS   = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  ip_ready,
    input  logic                  ip_end_frame,
    output logic [DATA_WIDTH-1:0] o_pixel,
    output logic                  o_pixel_valid,
    output logic [15:0]           o_x,
    output logic [15:0]           o_y,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_frame_err
`ifdef PIXEL_FEEDER_CHECKSUM_EN
    ,
    output logic [31:0]           o_checksum
`endif
);

    localparam logic [15:0] LAST_X = 16'(FRAME_WIDTH - 1);
    localparam logic [15:0] LAST_Y = 16'(FRAME_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DATA,
        S_SEND,
        S_WAIT_LOW,
        S_WAIT_END
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_pixel;
    logic                    r_pixel_valid;
    logic [15:0]             r_x;
    logic [15:0]             r_y;
    logic                    r_frame_done;
    logic                    r_frame_err;

    logic                    w_last;
    logic                    w_frame_start;
    logic                    w_restart;
    logic                    w_capture;
    logic                    w_advance;
    logic                    w_abort;
    logic                    w_complete;

    assign w_last = (r_x == LAST_X) && (r_y == LAST_Y);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_frame_start = 1'b0;
        w_restart     = 1'b0;
        w_capture     = 1'b0;
        w_advance     = 1'b0;
        w_abort       = 1'b0;
        w_complete    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_frame_start = 1'b1;
                    w_state_next  = S_FETCH;
                end
            end
            S_FETCH: begin
                if (ip_end_frame) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (ip_ready) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                // An early end here drops the pixel that was just read.
                if (ip_end_frame) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_capture    = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (ip_end_frame) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_last) begin
                    w_state_next = S_WAIT_END;
                end else begin
                    w_advance    = 1'b1;
                    w_state_next = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (ip_end_frame) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (!ip_ready) begin
                    w_state_next = S_FETCH;
                end
            end
            S_WAIT_END: begin
                if (ip_end_frame) begin
                    w_complete = 1'b1;
                    if ((CONTINUOUS != 0) || start) begin
                        w_restart    = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_addr    <= '0;
            r_pixel       <= '0;
            r_pixel_valid <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_pixel_valid <= w_capture;
            r_frame_done  <= w_abort | w_complete;
            if (w_frame_start || w_restart) begin
                r_mem_addr  <= '0;
                r_x         <= '0;
                r_y         <= '0;
                r_frame_err <= 1'b0;
            end
            if (w_abort) begin
                r_frame_err <= 1'b1;
            end
            if (w_capture) begin
                r_pixel <= mem_rdata;
            end
            // Raster address runs alongside x/y so no multiply is needed.
            if (w_advance) begin
                r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
                if (r_x == LAST_X) begin
                    r_x <= '0;
                    r_y <= r_y + 16'd1;
                end else begin
                    r_x <= r_x + 16'd1;
                end
            end
        end
    end

`ifdef PIXEL_FEEDER_CHECKSUM_EN
    logic [31:0] r_checksum;
    logic        r_ck_pending;

    // On an automatic restart the finished sum must stay visible during the
    // done pulse, so the clear is deferred to the first pixel of the new frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum   <= '0;
            r_ck_pending <= 1'b0;
        end else if (w_frame_start) begin
            r_checksum   <= '0;
            r_ck_pending <= 1'b0;
        end else if (w_restart) begin
            r_ck_pending <= 1'b1;
        end else if (w_capture) begin
            r_checksum   <= (r_ck_pending ? 32'd0 : r_checksum) + 32'(mem_rdata);
            r_ck_pending <= 1'b0;
        end
    end

    assign o_checksum = r_checksum;
`else
`endif

    assign mem_rd_en     = (r_state == S_FETCH) && ip_ready;
    assign mem_addr      = r_mem_addr;
    assign o_pixel       = r_pixel;
    assign o_pixel_valid = r_pixel_valid;
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_busy        = (r_state != S_IDLE);
    assign o_frame_done  = r_frame_done;
    assign o_frame_err   = r_frame_err;

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Bench for pixel_stream_feeder: instance 0 single-shot, instance 1 continuous,
// both on a 4x3 frame whose memory word k holds k+10.
module tb_pixel_stream_feeder;

    localparam int DW = 12;
    localparam int FW = 4;
    localparam int FH = 3;
    localparam int AW = 4;
    localparam int NPIX = FW * FH;

    logic          clk;
    logic          rst_n;
    logic          start   [2];
    logic          ready   [2];
    logic          endf    [2];
    logic          rd_en   [2];
    logic [AW-1:0] addr    [2];
    logic [DW-1:0] rdata   [2];
    logic [DW-1:0] pix     [2];
    logic          valid   [2];
    logic [15:0]   ox      [2];
    logic [15:0]   oy      [2];
    logic          busy    [2];
    logic          done    [2];
    logic          err     [2];
`ifdef PIXEL_FEEDER_CHECKSUM_EN
    logic [31:0]   cks     [2];
`endif

    int checks = 0;
    int errors = 0;
    int vcnt [2] = '{0, 0};
    int dcnt [2] = '{0, 0};

    pixel_stream_feeder #(.DATA_WIDTH(DW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
                          .ADDR_WIDTH(AW), .CONTINUOUS(0)) dut0 (
        .clk(clk), .reset_n(rst_n), .start(start[0]),
        .mem_rd_en(rd_en[0]), .mem_addr(addr[0]), .mem_rdata(rdata[0]),
        .ip_ready(ready[0]), .ip_end_frame(endf[0]),
        .o_pixel(pix[0]), .o_pixel_valid(valid[0]), .o_x(ox[0]), .o_y(oy[0]),
        .o_busy(busy[0]), .o_frame_done(done[0]), .o_frame_err(err[0])
`ifdef PIXEL_FEEDER_CHECKSUM_EN
        , .o_checksum(cks[0])
`endif
    );

    pixel_stream_feeder #(.DATA_WIDTH(DW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH),
                          .ADDR_WIDTH(AW), .CONTINUOUS(1)) dut1 (
        .clk(clk), .reset_n(rst_n), .start(start[1]),
        .mem_rd_en(rd_en[1]), .mem_addr(addr[1]), .mem_rdata(rdata[1]),
        .ip_ready(ready[1]), .ip_end_frame(endf[1]),
        .o_pixel(pix[1]), .o_pixel_valid(valid[1]), .o_x(ox[1]), .o_y(oy[1]),
        .o_busy(busy[1]), .o_frame_done(done[1]), .o_frame_err(err[1])
`ifdef PIXEL_FEEDER_CHECKSUM_EN
        , .o_checksum(cks[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read image memory: word k = k + 10.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i]) rdata[i] <= DW'(addr[i]) + DW'(10);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One ready-high episode: ready high for one cycle while in FETCH, then low.
    task automatic pulse_pixel(input int which);
        ready[which] = 1'b1;
        tick();
        ready[which] = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // Frame model: the n-th transfer of a frame carries pixel n+10 at (n%FW, n/FW).
    initial begin
        int k   [2];
        int sum [2];
        logic prev [2];
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; sum[i] = 0; prev[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    k[i] = 0; sum[i] = 0; prev[i] = 1'b0;
                end else begin
                    if (valid[i]) begin
                        chk($sformatf("single_pulse%0d", i), 32'(prev[i]), 32'd0);
                        chk($sformatf("pixel%0d", i), 32'(pix[i]), 32'(k[i] + 10));
                        chk($sformatf("x%0d", i), 32'(ox[i]), 32'(k[i] % FW));
                        chk($sformatf("y%0d", i), 32'(oy[i]), 32'(k[i] / FW));
                        sum[i] = sum[i] + k[i] + 10;
                        k[i] = (k[i] + 1) % NPIX;
                        vcnt[i]++;
                    end
                    if (done[i]) begin
                        dcnt[i]++;
`ifdef PIXEL_FEEDER_CHECKSUM_EN
                        if (!err[i]) chk($sformatf("checksum%0d", i), cks[i], 32'(sum[i]));
`endif
                        k[i] = 0;
                        sum[i] = 0;
                    end
                    prev[i] = valid[i];
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base_v;
        int base_d;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; ready[i] = 1'b0; endf[i] = 1'b0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pixel", 32'(pix[0]), 32'd0);
        chk("rst_valid", 32'(valid[0]), 32'd0);
        chk("rst_x", 32'(ox[0]), 32'd0);
        chk("rst_y", 32'(oy[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);
        chk("rst_err", 32'(err[0]), 32'd0);
        chk("rst_addr", 32'(addr[0]), 32'd0);
        chk("rst_rd_en", 32'(rd_en[0]), 32'd0);
        chk("rst_busy1", 32'(busy[1]), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Basic frame with first-pixel latency.
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        ready[0] = 1'b1;
        @(negedge clk);
        chk("lat_rd_en", 32'(rd_en[0]), 32'd1);
        chk("lat_addr", 32'(addr[0]), 32'd0);
        chk("lat_busy", 32'(busy[0]), 32'd1);
        tick();
        ready[0] = 1'b0;
        @(negedge clk);
        chk("lat_valid_n1", 32'(valid[0]), 32'd0);
        tick();
        ready[0] = 1'b1;
        @(negedge clk);
        chk("lat_valid_n2", 32'(valid[0]), 32'd1);
        chk("lat_pixel_n2", 32'(pix[0]), 32'd10);
        tick();
        ready[0] = 1'b0;
        tick();
        repeat (NPIX - 1) pulse_pixel(0);
        chk("frame_valid_count", 32'(vcnt[0]), 32'd12);
        chk("last_pixel", 32'(pix[0]), 32'd21);
        chk("last_xy", {ox[0], oy[0]}, {16'd3, 16'd2});
        endf[0] = 1'b1;
        tick();
        endf[0] = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(done[0]), 32'd1);
        chk("done_err", 32'(err[0]), 32'd0);
        chk("done_idle_busy", 32'(busy[0]), 32'd0);
`ifdef PIXEL_FEEDER_CHECKSUM_EN
        chk("checksum_186", cks[0], 32'd186);
`endif
        tick();
        @(negedge clk);
        chk("done_one_cycle", 32'(done[0]), 32'd0);
        chk("done_count", 32'(dcnt[0]), 32'd1);

        // Ready held high: one pixel only.
        tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        base_v = vcnt[0];
        ready[0] = 1'b1;
        repeat (20) tick();
        chk("held_one_pixel", 32'(vcnt[0] - base_v), 32'd1);
        ready[0] = 1'b0;
        tick();
        pulse_pixel(0);
        chk("held_second_pixel", 32'(vcnt[0] - base_v), 32'd2);
        chk("held_pixel_11", 32'(pix[0]), 32'd11);

        // Early end after the 5th pixel.
        repeat (3) pulse_pixel(0);
        endf[0] = 1'b1;
        tick();
        endf[0] = 1'b0;
        @(negedge clk);
        chk("abort_done", 32'(done[0]), 32'd1);
        chk("abort_err", 32'(err[0]), 32'd1);
        tick();
        @(negedge clk);
        chk("abort_idle", 32'(busy[0]), 32'd0);
        chk("abort_err_sticky", 32'(err[0]), 32'd1);
        tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        @(negedge clk);
        chk("start_clears_err", 32'(err[0]), 32'd0);
        tick();
        pulse_pixel(0);
        chk("restart_pixel_10", 32'(pix[0]), 32'd10);

        // Reset while in DATA.
        ready[0] = 1'b1;
        tick();
        ready[0] = 1'b0;
        base_v = vcnt[0];
        base_d = dcnt[0];
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid[0]), 32'd0);
        chk("arst_busy", 32'(busy[0]), 32'd0);
        chk("arst_pixel", 32'(pix[0]), 32'd0);
        chk("arst_x", 32'(ox[0]), 32'd0);
        chk("arst_addr", 32'(addr[0]), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("arst_no_valid", 32'(vcnt[0] - base_v), 32'd0);
        chk("arst_no_done", 32'(dcnt[0] - base_d), 32'd0);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (NPIX) pulse_pixel(0);
        chk("recover_count", 32'(vcnt[0] - base_v), 32'd12);
        endf[0] = 1'b1;
        tick();
        endf[0] = 1'b0;
        @(negedge clk);
        chk("recover_done", 32'(done[0]), 32'd1);
        tick();

        // Continuous mode: two frames from one start.
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        repeat (NPIX) pulse_pixel(1);
        endf[1] = 1'b1;
        tick();
        endf[1] = 1'b0;
        @(negedge clk);
        chk("cont_done1", 32'(done[1]), 32'd1);
        chk("cont_busy", 32'(busy[1]), 32'd1);
        chk("cont_addr0", 32'(addr[1]), 32'd0);
        tick();
        repeat (NPIX) pulse_pixel(1);
        endf[1] = 1'b1;
        tick();
        endf[1] = 1'b0;
        @(negedge clk);
        chk("cont_done2", 32'(done[1]), 32'd1);
        tick();
        chk("cont_valid_total", 32'(vcnt[1]), 32'd24);
        chk("cont_done_total", 32'(dcnt[1]), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_stream_feeder.md
Name: pixel_stream_feeder

Overview:
- Upstream stage of facial_detection_ip.
- Reads one frame of pixels in raster order from a synchronous-read image memory (image_container style, 1-cycle read latency).
- Delivers them one at a time over the detector's ready/valid pulse handshake.
- Tracks frame completion against the detector's end-of-frame flag.
- Replaces the ad-hoc testbench adapter with a synthesizable feeder.

Parameters:
- DATA_WIDTH, 12, pixel width.
- FRAME_WIDTH, 320, pixels per line.
- FRAME_HEIGHT, 240, lines per frame.
- ADDR_WIDTH, 17, memory address width; must hold FRAME_WIDTH*FRAME_HEIGHT-1.
- CONTINUOUS, 0, 1 = restart a new frame automatically after frame done.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  level; begins a frame when sampled high in IDLE.
- mem_rd_en  out  1  memory read enable (combinational).
- mem_addr  out  ADDR_WIDTH  memory address (registered).
- mem_rdata  in  DATA_WIDTH  memory data, valid 1 cycle after mem_rd_en.
- ip_ready  in  1  detector o_ready_recieve_pixel.
- ip_end_frame  in  1  detector o_end_frame.
- o_pixel  out  DATA_WIDTH  pixel to detector.
- o_pixel_valid  out  1  one-cycle pulse; drives detector end_recieve_pixel.
- o_x  out  16  column of the pixel in flight.
- o_y  out  16  row of the pixel in flight.
- o_busy  out  1  high in any state except IDLE.
- o_frame_done  out  1  one-cycle pulse at frame completion or abort.
- o_frame_err  out  1  sticky: detector ended the frame early.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; mem_addr=0, o_pixel=0, o_x=0, o_y=0; o_pixel_valid, o_busy, o_frame_done, o_frame_err all 0. Reset mid-frame aborts immediately with no done pulse.
- IDLE: start=1 -> clear o_frame_err, x=y=mem_addr=0, go FETCH.
- FETCH:
  - mem_rd_en = (state==FETCH && ip_ready).
  - When ip_ready=1 in cycle N: go DATA.
- DATA (cycle N+1): o_pixel <= mem_rdata, o_pixel_valid <= 1 at this edge; go SEND.
  - o_pixel_valid is high exactly in cycle N+2; o_pixel is held until the next transfer.
  - o_x/o_y show the coordinates of that pixel.
- SEND (cycle N+2), valid pulse:
  - Last pixel (x=FRAME_WIDTH-1, y=FRAME_HEIGHT-1): go WAIT_END.
  - Otherwise advance: x+1, or x=0 and y+1 at line end; mem_addr+1 (incremental, no multiplier). Go WAIT_LOW.
- WAIT_LOW: stay until ip_ready=0, then FETCH.
  - Exactly one pixel per ready-high episode; ready held high never causes a duplicate.
- WAIT_END: on ip_end_frame=1, pulse o_frame_done for 1 cycle.
  - Then, if CONTINUOUS=1 or start=1, restart at address 0 in FETCH; else IDLE.
- Early end: ip_end_frame=1 in FETCH, DATA, SEND or WAIT_LOW -> abort frame.
  - Set o_frame_err=1, pulse o_frame_done, go IDLE (no auto restart).
  - If the abort happens in DATA, o_pixel_valid is suppressed.
- ip_end_frame in IDLE is ignored.
- start outside IDLE is ignored except at the WAIT_END decision.

Optional Feature:
- Macro: PIXEL_FEEDER_CHECKSUM_EN.
- Defined:
  - Adds output o_checksum (32 bits): running sum of every transferred pixel, zero-extended, modulo 2^32.
  - Cleared on reset and at each frame start.
  - Frozen and valid while o_frame_done pulses, held until the next frame start.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- Setup: FRAME_WIDTH=4, FRAME_HEIGHT=3, memory word k = k+10.
- Basic frame: start pulse, ip_ready toggled 1-high/1-low per pixel.
  - Expect 12 valid pulses, pixels 10..21 in order, (o_x,o_y) from (0,0) to (3,2).
  - ip_end_frame after the 12th pulse -> one o_frame_done pulse, then IDLE, o_busy=0.
- Latency: ip_ready rises in cycle N while in FETCH -> mem_rd_en high in N, mem_addr=0, o_pixel_valid high in N+2 with o_pixel=10.
- Held ready: ip_ready held at 1 for 20 cycles -> exactly one pixel sent; the next pixel (11) only after ready falls and rises again.
- Early end: ip_end_frame asserted after the 5th pixel -> o_frame_err=1, o_frame_done pulse, IDLE. Next start clears o_frame_err and the frame restarts at pixel 10.
- CONTINUOUS=1: two frames back-to-back -> second frame restarts at mem_addr=0 with no start pulse; 24 valid pulses total; 2 done pulses.
- Reset mid-frame: reset_n=0 during DATA -> all outputs 0 asynchronously, no valid or done pulse; recovers on the next start.
- With PIXEL_FEEDER_CHECKSUM_EN defined: o_checksum=186 (sum of 10..21) during o_frame_done.
